// File: rtl/rms_pkg.sv
// -----------------------------------------------------------------------------
// rms_pkg
// Shared constants and state encoding for the RMS chain (averaging stage and
// square-root stage).
//   MEAN_W_DEF  : default width of the mean-square value
//   RMS_W_DEF   : default width of the root (half of MEAN_W_DEF)
//   rms_state_e : sequencing states IDLE / ITER / DONE
// -----------------------------------------------------------------------------
package rms_pkg;

    localparam int MEAN_W_DEF = 32;
    localparam int RMS_W_DEF  = MEAN_W_DEF / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } rms_state_e;

endpackage

// File: rtl/rms_sqrt_step.sv
// -----------------------------------------------------------------------------
// rms_sqrt_step
// One restoring digit step of an integer square root: brings down two operand
// bits and resolves one root bit.
// Ports:
//   rem_i  [RMS_W+1:0] : partial remainder before the step
//   root_i [RMS_W-1:0] : partial root before the step
//   bits_i [1:0]       : next two operand bits, MSB pair first
//   rem_o  [RMS_W+1:0] : partial remainder after the step
//   root_o [RMS_W-1:0] : partial root after the step
// -----------------------------------------------------------------------------
module rms_sqrt_step
    import rms_pkg::*;
#(
    parameter int RMS_W = RMS_W_DEF
) (
    input  logic [RMS_W+1:0] rem_i,
    input  logic [RMS_W-1:0] root_i,
    input  logic [1:0]       bits_i,
    output logic [RMS_W+1:0] rem_o,
    output logic [RMS_W-1:0] root_o
);

    localparam int REM_W = RMS_W + 2;

    logic [RMS_W+3:0] shifted;
    logic [RMS_W+3:0] trial;
    logic             take;

    // Trial subtrahend is 4*root + 1; the widened arithmetic keeps the compare
    // exact, and the remainder bound guarantees the result fits in REM_W bits.
    always_comb begin
        shifted = {rem_i, bits_i};
        trial   = {2'b00, root_i, 2'b01};
        take    = (shifted >= trial);
        rem_o   = take ? REM_W'(shifted - trial) : REM_W'(shifted);
        root_o  = RMS_W'({root_i, take});
    end

endmodule

// File: rtl/rms_sqrt.sv
// -----------------------------------------------------------------------------
// rms_sqrt
// Sequential integer square root of a mean-square value, one root bit per
// clock. Result is floor(sqrt(mean_in)); with RMS_SQRT_ROUND_EN defined the
// result is rounded to nearest and saturated at 2^RMS_W-1.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   mean_in    : unsigned mean-square operand (MEAN_W bits)
//   mean_valid : operand valid; accepted only while idle
//   busy       : conversion in flight
//   rms        : last computed root (RMS_W bits), held until next result
//   rms_valid  : one-cycle pulse with each new rms
//   dropped    : one-cycle pulse when mean_valid arrives while busy
//
// state | meaning
// IDLE  | waiting for mean_valid
// ITER  | one digit step per clock, RMS_W clocks
// DONE  | result presented (rms_valid high) for one cycle
// -----------------------------------------------------------------------------
module rms_sqrt
    import rms_pkg::*;
#(
    parameter int MEAN_W = MEAN_W_DEF,
    parameter int RMS_W  = MEAN_W / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MEAN_W-1:0] mean_in,
    input  logic              mean_valid,
    output logic              busy,
    output logic [RMS_W-1:0]  rms,
    output logic              rms_valid,
    output logic              dropped
);

    localparam int CNT_W = (RMS_W > 2) ? $clog2(RMS_W) : 1;

    rms_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MEAN_W-1:0] op_q, op_d;
    logic [RMS_W+1:0]  rem_q, rem_d;
    logic [RMS_W-1:0]  root_q, root_d;
    logic [RMS_W-1:0]  rms_q, rms_d;
    logic              rms_valid_q, rms_valid_d;
    logic              dropped_q, dropped_d;

    logic [RMS_W+1:0]  rem_n;
    logic [RMS_W-1:0]  root_n;
    logic [RMS_W-1:0]  result;

    rms_sqrt_step #(.RMS_W(RMS_W)) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (op_q[MEAN_W-1:MEAN_W-2]),
        .rem_o  (rem_n),
        .root_o (root_n)
    );

`ifdef RMS_SQRT_ROUND_EN
    // Remainder above the root means the true root is at least root + 0.5.
    logic round_up;
    always_comb begin
        round_up = (rem_n > {2'b00, root_n});
        result   = (round_up && !(&root_n)) ? root_n + RMS_W'(1) : root_n;
    end
`else
    assign result = root_n;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        rem_d       = rem_q;
        root_d      = root_q;
        rms_d       = rms_q;
        rms_valid_d = 1'b0;
        dropped_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mean_valid) begin
                    op_d    = mean_in;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CNT_W'(RMS_W - 1);
                    state_d = ITER;
                end
            end
            ITER: begin
                dropped_d = mean_valid;
                op_d      = {op_q[MEAN_W-3:0], 2'b00};
                rem_d     = rem_n;
                root_d    = root_n;
                if (cnt_q == '0) begin
                    // Result registers load on the last step so DONE shows them.
                    rms_d       = result;
                    rms_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                dropped_d = mean_valid;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            rms_q       <= '0;
            rms_valid_q <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            rms_q       <= rms_d;
            rms_valid_q <= rms_valid_d;
            dropped_q   <= dropped_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign rms       = rms_q;
    assign rms_valid = rms_valid_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_rms_sqrt.sv
// -----------------------------------------------------------------------------
// tb_rms_sqrt
// Directed and randomized checks of rms_sqrt against an arithmetic square-root
// reference. Build with RMS_SQRT_ROUND_EN defined to check the rounding build.
// -----------------------------------------------------------------------------
module tb_rms_sqrt;

`ifdef RMS_SQRT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    localparam int N_RAND = 3000;

    logic        clk;
    logic        rst_n;
    logic [31:0] mean_in;
    logic        mean_valid;
    logic        busy;
    logic [15:0] rms;
    logic        rms_valid;
    logic        dropped;

    int n_checks = 0;
    int n_errors = 0;

    rms_sqrt #(.MEAN_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mean_in    (mean_in),
        .mean_valid (mean_valid),
        .busy       (busy),
        .rms        (rms),
        .rms_valid  (rms_valid),
        .dropped    (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Nearest-or-floor integer square root from plain arithmetic.
    function automatic longint ref_rms(input longint x);
        longint r;
        r = longint'($sqrt(real'(x)));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        if (ROUND && (4 * x > (2 * r + 1) * (2 * r + 1)) && r < 65535) r++;
        return r;
    endfunction

    // Present x for exactly one accepting edge (edge k); returns just after it.
    task automatic start(input logic [31:0] x);
        @(negedge clk);
        mean_in    = x;
        mean_valid = 1'b1;
        @(negedge clk);
        mean_valid = 1'b0;
        mean_in    = $urandom;
    endtask

    // Waits for rms_valid; lat counts edges after the accepting edge.
    // inj_at > 0 raises mean_valid with inj_val for the edge k+inj_at+1.
    task automatic wait_result(input int inj_at, input logic [31:0] inj_val,
                               output int lat, output longint val, output int drops);
        lat   = -1;
        val   = -1;
        drops = 0;
        for (int m = 1; m <= 40; m++) begin
            @(negedge clk);
            if (dropped) drops++;
            if (rms_valid) begin
                lat = m;
                val = longint'(rms);
                break;
            end
            if (m == inj_at) begin
                mean_valid = 1'b1;
                mean_in    = inj_val;
            end else if (m == inj_at + 1) begin
                mean_valid = 1'b0;
            end
        end
    endtask

    task automatic quiet(input int n, output int valids, output int drops);
        valids = 0;
        drops  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rms_valid) valids++;
            if (dropped) drops++;
        end
    endtask

    task automatic directed(input string tag, input logic [31:0] x, input longint exp);
        int     lat;
        longint val;
        int     drops;
        start(x);
        check({tag, "_busy"}, longint'(busy), 1);
        wait_result(0, 32'd0, lat, val, drops);
        check({tag, "_lat"}, lat, 16);
        check({tag, "_rms"}, val, exp);
        @(negedge clk);
        check({tag, "_pulse"}, longint'(rms_valid), 0);
        check({tag, "_hold"}, longint'(rms), exp);
    endtask

    initial begin
        int     lat;
        longint val;
        int     drops, drops2, valids;
        longint exp_q[$];
        int     acc, got, cyc;
        logic [31:0] x;

        rst_n      = 1'b0;
        mean_valid = 1'b0;
        mean_in    = 32'd0;
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_rms", longint'(rms), 0);
        check("rst_valid", longint'(rms_valid), 0);
        check("rst_dropped", longint'(dropped), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        directed("zero", 32'd0, 0);
        directed("sq144", 32'd144, 12);
        directed("max", 32'hFFFF_FFFF, 65535);
        directed("v156", 32'd156, 12);
        directed("v157", 32'd157, ROUND ? 13 : 12);
        directed("v1", 32'd1, 1);
        directed("v2", 32'd2, 1);
        directed("v3", 32'd3, ROUND ? 2 : 1);

        // Overlapping request is dropped; in-flight result untouched.
        start(32'd144);
        wait_result(4, 32'd400, lat, val, drops);
        check("ovl_lat", lat, 16);
        check("ovl_rms", val, 12);
        quiet(20, valids, drops2);
        check("ovl_second_valid", valids, 0);
        check("ovl_dropped", drops + drops2, 1);
        directed("after_ovl", 32'd400, 20);

        // Reset mid-conversion aborts without a result.
        start(32'd1000);
        valids = 0;
        for (int m = 1; m <= 7; m++) begin
            @(negedge clk);
            if (rms_valid) valids++;
        end
        rst_n = 1'b0;
        #1;
        check("abort_rms", longint'(rms), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_valid", longint'(rms_valid), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet(20, lat, drops);
        check("abort_no_valid", valids + lat, 0);
        directed("after_rst", 32'd81, 9);

        // Back-to-back random stream: mean_valid held high throughout.
        acc = 0;
        got = 0;
        cyc = 0;
        while (got < N_RAND && cyc < N_RAND * 20) begin
            @(negedge clk);
            cyc++;
            if (rms_valid) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious", longint'(rms), -1);
                end else begin
                    check("rand_rms", longint'(rms), exp_q.pop_front());
                end
                got++;
            end
            case ($urandom_range(0, 7))
                0:       x = 32'hFFFF_FFFF - $urandom_range(0, 3);
                1:       x = $urandom_range(0, 300);
                2: begin
                    x = $urandom_range(0, 65535);
                    x = x * x + $urandom_range(0, 2);
                end
                default: x = $urandom;
            endcase
            mean_in    = x;
            mean_valid = (acc < N_RAND);
            if (mean_valid && !busy) begin
                exp_q.push_back(ref_rms(longint'(x)));
                acc++;
            end
        end
        mean_valid = 1'b0;
        quiet(20, valids, drops);
        check("rand_count", got + valids, acc);
        check("rand_accepts", acc, N_RAND);
        check("rand_leftover", exp_q.size() - valids, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
